fp_byte_link: RTL and testbench

Byte-serial host link that drives the FP32 add/sub datapath from an 8-bit valid/ready stream and returns its results.
- Receives a command byte, then operand A and operand B (4 bytes each, LSB first) on the input stream.
- Presents the assembled operands and the op select to the combinational adder, and captures the adder's 32-bit result.
- Streams the result back LSB first on the output stream.
- Sits between the chip's 8-bit I/O pins and the adder; the top level instantiates both blocks.

---
 rtl/fp_link_pkg.sv | 21 ++
 rtl/fp_byte_link.sv | 139 +++++++++++++
 tb/tb_fp_byte_link.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_link_pkg.sv
// Shared types and constants for the byte-serial FP32 add/sub host link.
package fp_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        SEND   = 3'd4
    } state_t;

    localparam logic [7:0] CMD_ADD        = 8'hA0;
    localparam logic [7:0] CMD_SUB        = 8'hA1;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_IDX       = 2'(BYTES_PER_WORD - 1);

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/fp_byte_link.sv
// Purpose: byte-serial host link feeding operands to the FP32 adder and streaming the result back.
// Latency: first result byte valid RESULT_WAIT+1 cycles after the last operand byte transfers.
// Backpressure: in_ready only in IDLE/LOAD_A/LOAD_B; out_data/out_valid hold while out_ready is low.
module fp_byte_link
    import fp_link_pkg::*;
#(
    parameter int RESULT_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_sub,
    input  logic [31:0] op_result,
    output logic        busy,
    output logic        cmd_err
);

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [3:0]  wcnt, wcnt_nx;
    logic [31:0] rslt;
    logic        op_sub_nx;
    logic        cmd_err_nx;
    logic        out_valid_nx;
    logic [7:0]  out_data_nx;
    logic        ld_a, ld_b, cap;
    logic        in_hs, out_hs;

    assign in_ready = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
    assign busy     = (state != IDLE);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wcnt_nx      = wcnt;
        op_sub_nx    = op_sub;
        cmd_err_nx   = 1'b0;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        cap          = 1'b0;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    if (in_data == CMD_ADD) begin
                        op_sub_nx = 1'b0;
                        cnt_nx    = 2'd0;
                        state_nx  = LOAD_A;
                    end else if (in_data == CMD_SUB) begin
                        op_sub_nx = 1'b1;
                        cnt_nx    = 2'd0;
                        state_nx  = LOAD_A;
                    end else begin
                        cmd_err_nx = 1'b1;
                    end
                end
            end
            LOAD_A: begin
                if (in_hs) begin
                    ld_a   = 1'b1;
                    cnt_nx = cnt + 2'd1;
                    if (cnt == LAST_IDX) state_nx = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    ld_b   = 1'b1;
                    cnt_nx = cnt + 2'd1;
                    if (cnt == LAST_IDX) begin
                        state_nx = WAIT;
                        wcnt_nx  = 4'(RESULT_WAIT);
                    end
                end
            end
            WAIT: begin
                wcnt_nx = wcnt - 4'd1;
                // Capture on the last wait cycle so a pipelined adder gets RESULT_WAIT cycles to settle.
                if (wcnt == 4'd1) begin
                    cap          = 1'b1;
                    cnt_nx       = 2'd0;
                    out_valid_nx = 1'b1;
                    out_data_nx  = op_result[7:0];
                    state_nx     = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    cnt_nx      = cnt + 2'd1;
                    out_data_nx = byte_sel(rslt, cnt + 2'd1);
                    if (cnt == LAST_IDX) begin
                        out_valid_nx = 1'b0;
                        state_nx     = IDLE;
                    end
                end
            end
            default: begin
                state_nx     = IDLE;
                out_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            wcnt      <= 4'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_sub    <= 1'b0;
            rslt      <= 32'd0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wcnt      <= wcnt_nx;
            op_sub    <= op_sub_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            cmd_err   <= cmd_err_nx;
            if (ld_a) op_a[8*cnt +: 8] <= in_data;
            if (ld_b) op_b[8*cnt +: 8] <= in_data;
            if (cap)  rslt <= op_result;
        end
    end

endmodule

// File: tb/tb_fp_byte_link.sv
// Drives two links (RESULT_WAIT=1 and 3) from one byte stream and checks them against a transaction-level model.
module tb_fp_byte_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready1, out_valid1, op_sub1, busy1, cmd_err1;
    logic [7:0]  out_data1;
    logic [31:0] op_a1, op_b1, op_result1;
    logic        in_ready3, out_valid3, op_sub3, busy3, cmd_err3;
    logic [7:0]  out_data3;
    logic [31:0] op_a3, op_b3, op_result3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] q1[$];
    logic [7:0] q3[$];
    int   rise1, rise3;
    logic pv1, pv3;
    logic in_hs_seen;

    always #5 clk = ~clk;

    // Stand-in for fp_addsub: exact FP results for the directed vectors, integer mix otherwise.
    function automatic logic [31:0] adder_stub(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s && a == 32'h3F800000 && b == 32'h3F800000) return 32'h00000000;
        if (s && a == 32'h7F800000 && b == 32'h7F800000) return 32'h7FC00000;
        return s ? (a - b) : (a + b);
    endfunction

    assign op_result1 = adder_stub(op_a1, op_b1, op_sub1);
    assign op_result3 = adder_stub(op_a3, op_b3, op_sub3);

    fp_byte_link #(.RESULT_WAIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .op_result(op_result1),
        .busy(busy1), .cmd_err(cmd_err1)
    );

    fp_byte_link #(.RESULT_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .op_a(op_a3), .op_b(op_b3), .op_sub(op_sub3), .op_result(op_result3),
        .busy(busy3), .cmd_err(cmd_err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes before the edge, check stall stability and busy release after it.
    task automatic tick();
        logic       hs1, hs3, st1, st3, last1;
        logic [7:0] d1, d3;
        hs1 = out_valid1 && out_ready;
        hs3 = out_valid3 && out_ready;
        st1 = out_valid1 && !out_ready && rst_n;
        st3 = out_valid3 && !out_ready && rst_n;
        d1  = out_data1;
        d3  = out_data3;
        if (hs1) q1.push_back(out_data1);
        if (hs3) q3.push_back(out_data3);
        last1 = hs1 && (q1.size() == 4);
        in_hs_seen = in_valid && in_ready1 && in_ready3;
        pv1 = out_valid1;
        pv3 = out_valid3;
        @(posedge clk);
        #1;
        cyc++;
        if (st1) begin
            chk("stall_valid1", out_valid1, 1);
            chk("stall_data1", out_data1, d1);
        end
        if (st3) begin
            chk("stall_valid3", out_valid3, 1);
            chk("stall_data3", out_data3, d3);
        end
        if (last1) begin
            chk("busy_drop1", busy1, 0);
            chk("in_ready_back1", in_ready1, 1);
        end
        if (out_valid1 && !pv1 && rise1 < 0) rise1 = cyc;
        if (out_valid3 && !pv3 && rise3 < 0) rise3 = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int hs_cyc);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_hs_seen = 1'b0;
        while (!in_hs_seen && n < 100) begin
            tick();
            n++;
        end
        if (!in_hs_seen) chk("in_handshake_timeout", 0, 1);
        hs_cyc   = cyc;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready1 && in_ready3 && !busy1 && !busy3) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input bit gaps, input bit bp, input bit stall, output logic [31:0] got);
        int hs, dummy, n;
        bit stalled;
        logic [31:0] exp, got3;
        wait_idle();
        q1.delete();
        q3.delete();
        rise1 = -1;
        rise3 = -1;
        out_ready = 1'b1;
        stalled = 1'b0;
        send_byte(cmd, gaps ? int'($urandom_range(0, 3)) : 0, dummy);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0, dummy);
        for (int i = 0; i < 3; i++) send_byte(b[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0, dummy);
        send_byte(b[31:24], 0, hs);
        chk("op_a1", op_a1, a);
        chk("op_b1", op_b1, b);
        chk("op_sub1", op_sub1, cmd[0]);
        chk("op_a3", op_a3, a);
        chk("op_b3", op_b3, b);
        chk("busy_wait", busy1, 1);
        chk("in_ready_wait", in_ready1, 0);
        exp = adder_stub(a, b, cmd[0]);
        n = 0;
        while ((q1.size() < 4 || q3.size() < 4) && n < 300) begin
            if (stall && !stalled && q1.size() == 1 && out_valid1) begin
                out_ready = 1'b0;
                repeat (3) tick();
                chk("stall_byte1", out_data1, exp[15:8]);
                stalled = 1'b1;
                out_ready = 1'b1;
            end else begin
                out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                tick();
            end
            n++;
        end
        out_ready = 1'b1;
        if (n >= 300) chk("out_timeout", 0, 1);
        // Handshake cycle t ends at edge hs; out_valid must first be seen in cycle t+1+RESULT_WAIT.
        chk("latency_rw1", rise1 - hs, 1);
        chk("latency_rw3", rise3 - hs, 3);
        got  = {q1.size() > 3 ? q1[3] : 8'hxx, q1.size() > 2 ? q1[2] : 8'hxx,
                q1.size() > 1 ? q1[1] : 8'hxx, q1.size() > 0 ? q1[0] : 8'hxx};
        got3 = {q3.size() > 3 ? q3[3] : 8'hxx, q3.size() > 2 ? q3[2] : 8'hxx,
                q3.size() > 1 ? q3[1] : 8'hxx, q3.size() > 0 ? q3[0] : 8'hxx};
        chk("result1", got, exp);
        chk("result3", got3, exp);
    endtask

    initial begin
        logic [31:0] got, ra, rb;
        logic [7:0]  rc, bad;
        int dummy;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        rise1 = -1;
        rise3 = -1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_data", out_data1, 0);
        chk("rst_op_a", op_a1, 0);
        chk("rst_op_b", op_b1, 0);
        chk("rst_op_sub", op_sub1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_cmd_err", cmd_err1, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready1, 1);

        // 1.0 + 2.0
        txn(8'hA0, 32'h3F800000, 32'h40000000, 0, 0, 0, got);
        chk("dir_add", got, 32'h40400000);
        // 1.0 - 1.0
        txn(8'hA1, 32'h3F800000, 32'h3F800000, 0, 0, 0, got);
        chk("dir_sub_zero", got, 32'h00000000);
        // inf - inf with a stall on byte 1
        txn(8'hA1, 32'h7F800000, 32'h7F800000, 0, 0, 1, got);
        chk("dir_inf_nan", got, 32'h7FC00000);

        // illegal command byte
        wait_idle();
        send_byte(8'h55, 0, dummy);
        chk("cmd_err_pulse", cmd_err1, 1);
        chk("cmd_err_in_ready", in_ready1, 1);
        chk("cmd_err_busy", busy1, 0);
        tick();
        chk("cmd_err_clear", cmd_err1, 0);
        txn(8'hA0, 32'h3F800000, 32'h40000000, 0, 0, 0, got);
        chk("after_err_add", got, 32'h40400000);

        // reset in the middle of operand B
        wait_idle();
        send_byte(8'hA0, 0, dummy);
        for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1), 0, dummy);
        send_byte(8'h77, 0, dummy);
        send_byte(8'h88, 0, dummy);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_out_valid", out_valid1, 0);
        chk("mid_rst_op_a", op_a1, 0);
        chk("mid_rst_op_b", op_b1, 0);
        chk("mid_rst_in_ready", in_ready1, 1);
        chk("mid_rst_busy3", busy3, 0);
        txn(8'hA0, 32'h3F800000, 32'h40000000, 1, 0, 0, got);
        chk("after_rst_add", got, 32'h40400000);

        // randomized transactions with input gaps and output backpressure
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                bad = 8'($urandom);
                if (bad == 8'hA0 || bad == 8'hA1) bad = 8'h00;
                send_byte(bad, 0, dummy);
                chk("rnd_cmd_err", cmd_err1, 1);
            end
            ra = $urandom;
            rb = $urandom;
            rc = ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hA0;
            txn(rc, ra, rb, 1, 1, 0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
